// File: rtl/bsg_level_shift_pkg.sv
// Shared types and helpers for the v0->v1 level-shift / isolation sequencer.
package bsg_level_shift_pkg;

  typedef enum logic [1:0] {
    S_ISO    = 2'd0,
    S_SETTLE = 2'd1,
    S_ON     = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // Counter wide enough to hold the larger of the two preload values.
  function automatic int unsigned ctr_width(input int unsigned settle,
                                            input int unsigned hold);
    int unsigned m;
    m = (settle > hold) ? settle : hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bsg_level_shift_clamp.sv
// One isolation clamp cell: passes data only when released and enabled.
module bsg_level_shift_clamp #(
  parameter int unsigned           width_p     = 16,
  parameter logic [width_p-1:0]    clamp_val_p = '0
) (
  input  logic               iso_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_comb begin
    data_o = clamp_val_p;
    if (!iso_i && en_i) begin
      data_o = data_i;
    end
  end

endmodule

// File: rtl/bsg_level_shift_iso_seq.sv
// Multi-channel v0->v1 level shifter with power-sequencing FSM and isolation clamps.
// Optional BSG_LEVEL_SHIFT_RETIME_EN registers v1_data_o for one extra cycle of latency.
module bsg_level_shift_iso_seq
  import bsg_level_shift_pkg::*;
#(
  parameter int unsigned        width_p         = 16,
  parameter int unsigned        num_chan_p      = 2,
  parameter int unsigned        settle_cycles_p = 4,
  parameter int unsigned        hold_cycles_p   = 2,
  parameter logic [width_p-1:0] clamp_val_p     = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          pwr_on_req_i,
  output logic                          pwr_on_ack_o,
  output logic                          iso_o,
  input  logic [num_chan_p-1:0]         v0_en_i,
  input  logic [num_chan_p*width_p-1:0] v0_data_i,
  output logic [num_chan_p*width_p-1:0] v1_data_o
);

  localparam int unsigned CtrW = ctr_width(settle_cycles_p, hold_cycles_p);
  localparam logic [CtrW-1:0] SettleInit = CtrW'(settle_cycles_p - 1);
  localparam logic [CtrW-1:0] HoldInit   = CtrW'(hold_cycles_p - 1);
  localparam logic [CtrW-1:0] CtrOne     = CtrW'(1);

  state_e          state_q, state_d;
  logic [CtrW-1:0] cnt_q, cnt_d;
  logic            iso_q, iso_d;
  logic            ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_ISO: begin
        if (pwr_on_req_i) begin
          state_d = S_SETTLE;
          cnt_d   = SettleInit;
        end
      end
      S_SETTLE: begin
        if (!pwr_on_req_i) begin
          state_d = S_ISO;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - CtrOne;
        end
      end
      S_ON: begin
        if (!pwr_on_req_i) begin
          state_d = S_HOLD;
          cnt_d   = HoldInit;
        end
      end
      S_HOLD: begin
        // req is deliberately ignored here; only S_ISO can start a new settle.
        if (cnt_q == '0) begin
          state_d = S_ISO;
        end else begin
          cnt_d = cnt_q - CtrOne;
        end
      end
      default: begin
        state_d = S_ISO;
        cnt_d   = '0;
      end
    endcase
  end

  // iso/ack are flopped from the next state so outputs never see req glitches.
  always_comb begin
    iso_d = (state_d != S_ON);
    ack_d = (state_d == S_ON) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_ISO;
      cnt_q   <= '0;
      iso_q   <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iso_q   <= iso_d;
      ack_q   <= ack_d;
    end
  end

  assign iso_o        = iso_q;
  assign pwr_on_ack_o = ack_q;

  logic [num_chan_p*width_p-1:0] gated_w;

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bsg_level_shift_clamp #(
      .width_p     (width_p),
      .clamp_val_p (clamp_val_p)
    ) u_clamp (
      .iso_i  (iso_q),
      .en_i   (v0_en_i[c]),
      .data_i (v0_data_i[c*width_p +: width_p]),
      .data_o (gated_w[c*width_p +: width_p])
    );
  end

`ifdef BSG_LEVEL_SHIFT_RETIME_EN
  logic [num_chan_p*width_p-1:0] data_q, data_d;

  always_comb begin
    data_d = gated_w;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= {num_chan_p{clamp_val_p}};
    end else begin
      data_q <= data_d;
    end
  end

  assign v1_data_o = data_q;
`else
  assign v1_data_o = gated_w;
`endif

endmodule

// File: tb/tb_bsg_level_shift_iso_seq.sv
// Directed self-checking bench for bsg_level_shift_iso_seq (default parameters).
module tb_bsg_level_shift_iso_seq;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        ack;
  logic        iso;
  logic [1:0]  en;
  logic [31:0] din;
  logic [31:0] dout;

  int total = 0;
  int bad   = 0;

  bsg_level_shift_iso_seq #(
    .width_p         (16),
    .num_chan_p      (2),
    .settle_cycles_p (4),
    .hold_cycles_p   (2),
    .clamp_val_p     (16'h0000)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .pwr_on_req_i (req),
    .pwr_on_ack_o (ack),
    .iso_o        (iso),
    .v0_en_i      (en),
    .v0_data_i    (din),
    .v1_data_o    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Time for input changes to reach v1_data_o (extra edge when retimed).
  task automatic data_settle;
`ifdef BSG_LEVEL_SHIFT_RETIME_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req     = 1'b0;
    en      = 2'b11;
    din     = 32'hFFFF_FFFF;
    #12;
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL reset_iso got=%b exp=1", iso); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=%h", dout, 32'h0); end
    reset_n = 1'b1;
    tick();
    tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL idle_iso got=%b exp=1", iso); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL idle_data got=%h exp=%h", dout, 32'h0); end
  endtask

  task automatic test_power_on;
    din = {16'h3C3C, 16'hA5A5};
    en  = 2'b11;
    req = 1'b1;
    repeat (4) tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL settle4_iso got=%b exp=1", iso); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL settle4_ack got=%b exp=0", ack); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL settle4_data got=%h exp=%h", dout, 32'h0); end
    tick();
    total++; if (iso !== 1'b0) begin bad++; $display("FAIL on_iso got=%b exp=0", iso); end
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL on_ack got=%b exp=1", ack); end
`ifdef BSG_LEVEL_SHIFT_RETIME_EN
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL on_data_lag got=%h exp=%h", dout, 32'h0); end
    tick();
`endif
    total++; if (dout !== 32'h3C3C_A5A5) begin bad++; $display("FAIL on_data got=%h exp=%h", dout, 32'h3C3C_A5A5); end
  endtask

  task automatic test_enable_mask;
    en = 2'b10;
    data_settle();
    total++; if (dout !== 32'h3C3C_0000) begin bad++; $display("FAIL en10_data got=%h exp=%h", dout, 32'h3C3C_0000); end
    en = 2'b01;
    data_settle();
    total++; if (dout !== 32'h0000_A5A5) begin bad++; $display("FAIL en01_data got=%h exp=%h", dout, 32'h0000_A5A5); end
    en  = 2'b11;
    din = {16'hFFFF, 16'h1234};
    data_settle();
    total++; if (dout !== 32'hFFFF_1234) begin bad++; $display("FAIL en11_data got=%h exp=%h", dout, 32'hFFFF_1234); end
  endtask

  task automatic test_power_off;
    req = 1'b0;
    tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL off_iso got=%b exp=1", iso); end
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL off_ack1 got=%b exp=1", ack); end
`ifdef BSG_LEVEL_SHIFT_RETIME_EN
    total++; if (dout !== 32'hFFFF_1234) begin bad++; $display("FAIL off_data_lag got=%h exp=%h", dout, 32'hFFFF_1234); end
`else
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL off_data got=%h exp=%h", dout, 32'h0); end
`endif
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL off_ack2 got=%b exp=1", ack); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL off_data2 got=%h exp=%h", dout, 32'h0); end
    tick();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL off_ack3 got=%b exp=0", ack); end
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL off_iso3 got=%b exp=1", iso); end
  endtask

  task automatic test_abort;
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    tick();
    tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL abort_iso got=%b exp=1", iso); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", ack); end
    req = 1'b1;
    repeat (4) tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL abort_resettle_iso got=%b exp=1", iso); end
    tick();
    total++; if (iso !== 1'b0) begin bad++; $display("FAIL abort_on_iso got=%b exp=0", iso); end
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL abort_on_ack got=%b exp=1", ack); end
  endtask

  task automatic test_hold_reassert;
    req = 1'b0;
    tick();
    req = 1'b1;
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL hold_ack got=%b exp=1", ack); end
    tick();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL hold_end_ack got=%b exp=0", ack); end
    repeat (4) tick();
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL hold_resettle_iso got=%b exp=1", iso); end
    tick();
    total++; if (iso !== 1'b0) begin bad++; $display("FAIL hold_on_iso got=%b exp=0", iso); end
  endtask

  task automatic test_reset_mid_hold;
    din = {16'h5A5A, 16'hC3C3};
    en  = 2'b11;
    data_settle();
    total++; if (dout !== 32'h5A5A_C3C3) begin bad++; $display("FAIL pre_reset_data got=%h exp=%h", dout, 32'h5A5A_C3C3); end
    req = 1'b0;
    tick();
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL pre_reset_ack got=%b exp=1", ack); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL async_ack got=%b exp=0", ack); end
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL async_iso got=%b exp=1", iso); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL async_data got=%h exp=%h", dout, 32'h0); end
    #3;
    reset_n = 1'b1;
    tick();
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL post_reset_ack got=%b exp=0", ack); end
    total++; if (iso !== 1'b1) begin bad++; $display("FAIL post_reset_iso got=%b exp=1", iso); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_enable_mask();
    test_power_off();
    test_abort();
    test_hold_reassert();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
